instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 133 +++++++++++++
 tb/tb_instr_fetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch: single-stage instruction fetch with a one-entry output register.
//
// After reset the block spends one BOOT cycle presenting RESET_PC, then fetches
// continuously. A word is accepted when memory acknowledges and neither a stall
// nor a redirect is active. An accepted word is latched into the if_* register
// on the next edge. On that same edge the PC steps to the predicted target or
// to PC+4. Redirect overrides everything else. Stall freezes the PC, the output
// register and the counters.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   IAD           instruction address (combinational copy of the PC)
//   IDT, ACKI_n   returned instruction word and its active-low acknowledge
//   stall         hold request from decode
//   redirect      PC correction from execute, target on redirect_pc
//   pred_taken    predictor decision for the current IAD
//   pred_target   predicted target for the current IAD
//   if_valid      output register holds a live instruction
//   if_pc         address of the latched instruction
//   if_instr      latched instruction word
//   if_pred       prediction captured with the instruction
//   if_is_branch  latched word decodes as a branch
//   fetch_count   saturating count of accepted instructions
//   branch_count  saturating count of accepted branches
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned          BIT_WIDTH = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_PC  = BIT_WIDTH'(32'h0001_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [BIT_WIDTH-1:0] IAD,
    input  logic [BIT_WIDTH-1:0] IDT,
    input  logic                 ACKI_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [BIT_WIDTH-1:0] redirect_pc,
    input  logic                 pred_taken,
    input  logic [BIT_WIDTH-1:0] pred_target,
    output logic                 if_valid,
    output logic [BIT_WIDTH-1:0] if_pc,
    output logic [BIT_WIDTH-1:0] if_instr,
    output logic                 if_pred,
    output logic                 if_is_branch,
    output logic [31:0]          fetch_count,
    output logic [31:0]          branch_count
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        BOOT  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t               state;
    logic [BIT_WIDTH-1:0] pc;
    logic                 accept_c;
    logic                 is_branch_c;
    logic [BIT_WIDTH-1:0] pc_plus4_c;
    logic [BIT_WIDTH-1:0] pc_next_seq_c;

    // Address bus mirrors the PC directly so memory sees it in the same cycle.
    assign IAD = pc;

    // A word is taken only in FETCH, when it is acknowledged and nothing blocks it.
    assign accept_c = (state == FETCH) && !ACKI_n && !stall && !redirect;

    // Branch opcodes: 6'b000001 in the top six bits, or 4'b0001 in the top nibble.
    assign is_branch_c = (IDT[BIT_WIDTH-1 -: 6] == 6'b000001) ||
                         (IDT[BIT_WIDTH-1 -: 4] == 4'b0001);

    // Sequential successor wraps naturally at the top of the address space.
    assign pc_plus4_c    = pc + BIT_WIDTH'(4);
    assign pc_next_seq_c = pred_taken ? pred_target : pc_plus4_c;

    // State, PC, output register and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            if_pred      <= 1'b0;
            if_is_branch <= 1'b0;
            fetch_count  <= '0;
            branch_count <= '0;
        end else begin
            case (state)
                BOOT: begin
                    // One idle cycle at RESET_PC; an early redirect still lands.
                    state    <= FETCH;
                    if_valid <= 1'b0;
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                end
                FETCH: begin
                    if (redirect) begin
                        pc       <= redirect_pc;
                        if_valid <= 1'b0;
                    end else if (stall) begin
                        // Everything holds; any returned word is refetched later.
                        pc       <= pc;
                        if_valid <= if_valid;
                    end else if (ACKI_n) begin
                        if_valid <= 1'b0;
                    end else if (accept_c) begin
                        pc           <= pc_next_seq_c;
                        if_valid     <= 1'b1;
                        if_pc        <= pc;
                        if_instr     <= IDT;
                        if_pred      <= pred_taken;
                        if_is_branch <= is_branch_c;
                        if (fetch_count != CNT_MAX) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                        if (is_branch_c && (branch_count != CNT_MAX)) begin
                            branch_count <= branch_count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch: directed vector table for instr_fetch plus hand sequences for
// asynchronous reset mid-stall, first acceptance after reset and BOOT redirect.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] IAD;
    logic [31:0] IDT;
    logic        ACKI_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_pred;
    logic        if_is_branch;
    logic [31:0] fetch_count;
    logic [31:0] branch_count;

    int n_cmp;
    int n_err;

    instr_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .IAD          (IAD),
        .IDT          (IDT),
        .ACKI_n       (ACKI_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .if_pred      (if_pred),
        .if_is_branch (if_is_branch),
        .fetch_count  (fetch_count),
        .branch_count (branch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack_n;
        logic        stl;
        logic        redir;
        logic [31:0] rpc;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] idt;
        logic [31:0] e_iad;
        logic        e_valid;
        logic        chk;      // payload fields are checked only when defined
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_pred;
        logic        e_br;
        logic [31:0] e_fc;
        logic [31:0] e_bc;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic s, input logic r, input logic [31:0] rp,
                         input logic p, input logic [31:0] pg, input logic [31:0] d);
        ACKI_n      = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        pred_taken  = p;
        pred_target = pg;
        IDT         = d;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " iad"},   IAD,                  32'h0001_0000);
        check({tag, " valid"}, 32'(if_valid),        32'd0);
        check({tag, " pc"},    if_pc,                32'd0);
        check({tag, " instr"}, if_instr,             32'd0);
        check({tag, " pred"},  32'(if_pred),         32'd0);
        check({tag, " br"},    32'(if_is_branch),    32'd0);
        check({tag, " fc"},    fetch_count,          32'd0);
        check({tag, " bc"},    branch_count,         32'd0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0020);

        //          ack  stl  red  rpc           pt   ptgt          idt            e_iad         v    chk  e_pc          e_instr       pr   br   fc     bc
        tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0000,1'b0,1'b1,32'h0,        32'h0,        1'b0,1'b0,32'd0, 32'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0004,1'b1,1'b1,32'h0001_0000,32'h0000_0020,1'b0,1'b0,32'd1, 32'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0008,1'b1,1'b1,32'h0001_0004,32'h0000_0020,1'b0,1'b0,32'd2, 32'd0};
        tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_000C,1'b1,1'b1,32'h0001_0008,32'h0000_0020,1'b0,1'b0,32'd3, 32'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0010,1'b1,1'b1,32'h0001_000C,32'h0000_0020,1'b0,1'b0,32'd4, 32'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h0001_0040,32'h1000_0004, 32'h0001_0040,1'b1,1'b1,32'h0001_0010,32'h1000_0004,1'b1,1'b1,32'd5, 32'd1};
        tbl[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0001_2340,32'hDEAD_0000, 32'h0001_0040,1'b1,1'b1,32'h0001_0010,32'h1000_0004,1'b1,1'b1,32'd5, 32'd1};
        tbl[7]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0001_2340,32'hDEAD_0000, 32'h0001_0040,1'b1,1'b1,32'h0001_0010,32'h1000_0004,1'b1,1'b1,32'd5, 32'd1};
        tbl[8]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0001_2340,32'hDEAD_0000, 32'h0001_0040,1'b1,1'b1,32'h0001_0010,32'h1000_0004,1'b1,1'b1,32'd5, 32'd1};
        tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0400_0000, 32'h0001_0044,1'b1,1'b1,32'h0001_0040,32'h0400_0000,1'b0,1'b1,32'd6, 32'd2};
        tbl[10] = '{1'b0,1'b1,1'b1,32'h0001_0100,1'b1,32'h0005_5550,32'h0000_0020, 32'h0001_0100,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd6, 32'd2};
        tbl[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0104,1'b1,1'b1,32'h0001_0100,32'h0000_0020,1'b0,1'b0,32'd7, 32'd2};
        tbl[12] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0104,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd7, 32'd2};
        tbl[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0108,1'b1,1'b1,32'h0001_0104,32'h0000_0020,1'b0,1'b0,32'd8, 32'd2};
        tbl[14] = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_0108,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd8, 32'd2};
        tbl[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0001_010C,1'b1,1'b1,32'h0001_0108,32'h0000_0020,1'b0,1'b0,32'd9, 32'd2};
        tbl[16] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0,        32'h0000_0020, 32'hFFFF_FFFC,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd9, 32'd2};
        tbl[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        32'h0000_0020, 32'h0000_0000,1'b1,1'b1,32'hFFFF_FFFC,32'h0000_0020,1'b0,1'b0,32'd10,32'd2};
        tbl[18] = '{1'b1,1'b0,1'b0,32'h0,        1'b1,32'h0000_5000,32'h1000_0004, 32'h0000_0000,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,32'd10,32'd2};

        // Values held while reset is asserted.
        #1;
        check_reset_values("rst_hold");
        tick();
        tick();
        check_reset_values("rst_hold_clk");
        rst = 1'b0;

        // Table-driven run from reset release.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].ack_n, tbl[i].stl, tbl[i].redir, tbl[i].rpc,
                  tbl[i].pt, tbl[i].ptgt, tbl[i].idt);
            tick();
            check($sformatf("v%0d iad", i),   IAD,               tbl[i].e_iad);
            check($sformatf("v%0d valid", i), 32'(if_valid),     32'(tbl[i].e_valid));
            check($sformatf("v%0d fc", i),    fetch_count,       tbl[i].e_fc);
            check($sformatf("v%0d bc", i),    branch_count,      tbl[i].e_bc);
            if (tbl[i].chk) begin
                check($sformatf("v%0d pc", i),    if_pc,              tbl[i].e_pc);
                check($sformatf("v%0d instr", i), if_instr,           tbl[i].e_instr);
                check($sformatf("v%0d pred", i),  32'(if_pred),       32'(tbl[i].e_pred));
                check($sformatf("v%0d br", i),    32'(if_is_branch),  32'(tbl[i].e_br));
            end
        end

        // One more acceptance at address 0, then stall and assert reset mid-cycle.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0020);
        tick();
        check("wrap_next iad", IAD,          32'h0000_0004);
        check("wrap_next pc",  if_pc,        32'h0000_0000);
        check("wrap_next fc",  fetch_count,  32'd11);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0020);
        tick();
        check("stall2 iad", IAD,           32'h0000_0004);
        check("stall2 valid", 32'(if_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        tick();
        rst = 1'b0;

        // First acceptance after reset only on the second rising edge.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0020);
        tick();
        check("post_rst e1 valid", 32'(if_valid), 32'd0);
        check("post_rst e1 fc",    fetch_count,   32'd0);
        check("post_rst e1 iad",   IAD,           32'h0001_0000);
        tick();
        check("post_rst e2 valid", 32'(if_valid), 32'd1);
        check("post_rst e2 pc",    if_pc,         32'h0001_0000);
        check("post_rst e2 fc",    fetch_count,   32'd1);

        // Redirect during BOOT still lands and still moves to FETCH.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h0002_0000, 1'b0, 32'd0, 32'h0000_0020);
        tick();
        check("boot_redir iad",   IAD,           32'h0002_0000);
        check("boot_redir valid", 32'(if_valid), 32'd0);
        check("boot_redir fc",    fetch_count,   32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0400_0000);
        tick();
        check("boot_redir acc valid", 32'(if_valid), 32'd1);
        check("boot_redir acc pc",    if_pc,         32'h0002_0000);
        check("boot_redir acc iad",   IAD,           32'h0002_0004);
        check("boot_redir acc bc",    branch_count,  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
